// File: rtl/pipe_stall_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipe_stall_ctrl_pkg
// Purpose  : Shared stall-bus width, thermometer stall codes and mul/div FSM states.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_stall_ctrl_pkg;

    localparam int c_STALL_W = 6;

    // Thermometer codes: bit0 = PC ... bit5 = WB, 1 = Stop
    localparam logic [c_STALL_W-1:0] c_STALL_NONE = 6'b000000;
    localparam logic [c_STALL_W-1:0] c_STALL_ID   = 6'b000111;
    localparam logic [c_STALL_W-1:0] c_STALL_EX   = 6'b001111;
    localparam logic [c_STALL_W-1:0] c_STALL_MEM  = 6'b011111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DIV_WAIT = 3'd2,
        S_MUL_CNT  = 3'd3,
        S_DONE     = 3'd4
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
//------------------------------------------------------------------------------
// Module   : hazard_detect
// Purpose  : Combinational load-use compare between the ID sources and the EX load.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_detect (
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_use_rs,
    input  logic       i_id_use_rt,
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rf_waddr,
    output logic       o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_id_use_rs && (i_id_rs == i_ex_rf_waddr);
    assign w_rt_match = i_id_use_rt && (i_id_rt == i_ex_rf_waddr);

    // $zero is never a real producer, so a load into it cannot create a hazard
    assign o_hazard = i_id_valid && i_ex_valid && i_ex_is_load &&
                      (i_ex_rf_waddr != 5'd0) && (w_rs_match || w_rt_match);

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pipe_stall_ctrl
// Purpose  : Merges load-use, mul/div sequencing and data-SRAM wait into the stall bus.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MUL_LAT     = 3,
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_rf_waddr,
    input  logic                 ex_md_req,
    input  logic                 ex_md_is_div,
    input  logic                 md_done,
    input  logic                 mem_stallreq,
    output logic                 md_start,
    output logic                 md_result_we,
    output logic                 md_timeout,
    output logic [c_STALL_W-1:0] stall,
    output logic                 md_busy
);

    md_state_e        r_state_q;
    md_state_e        w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_md_timeout_q;
    logic             w_md_timeout_d;

    logic                 w_hazard;
    logic [c_STALL_W-1:0] w_lu_stall;
    logic [c_STALL_W-1:0] w_md_stall;
    logic [c_STALL_W-1:0] w_mem_stall;

    hazard_detect u_hazard_detect (
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_use_rs   (id_use_rs),
        .i_id_use_rt   (id_use_rt),
        .i_ex_valid    (ex_valid),
        .i_ex_is_load  (ex_is_load),
        .i_ex_rf_waddr (ex_rf_waddr),
        .o_hazard      (w_hazard)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q      <= S_IDLE;
            r_cnt_q        <= '0;
            r_md_timeout_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_md_timeout_q <= w_md_timeout_d;
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_md_timeout_d = r_md_timeout_q;
        case (r_state_q)
            S_IDLE: begin
                if (ex_md_req && ex_valid) begin
                    w_state_d = S_START;
                end
            end
            S_START: begin
                w_cnt_d   = '0;
                w_state_d = ex_md_is_div ? S_DIV_WAIT : S_MUL_CNT;
            end
            S_MUL_CNT: begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
                if (r_cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    w_state_d = S_DONE;
                end
            end
            S_DIV_WAIT: begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
                if (md_done) begin
                    w_state_d = S_DONE;
                end else if (r_cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                    // Release the pipeline with a garbage result rather than hang
                    w_md_timeout_d = 1'b1;
                    w_state_d      = S_DONE;
                end
            end
            S_DONE: begin
                // The requesting instruction is still in EX here; do not re-accept it
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign w_lu_stall  = w_hazard     ? c_STALL_ID  : c_STALL_NONE;
    assign w_mem_stall = mem_stallreq ? c_STALL_MEM : c_STALL_NONE;
    assign w_md_stall  = ((r_state_q == S_START) || (r_state_q == S_DIV_WAIT) ||
                          (r_state_q == S_MUL_CNT)) ? c_STALL_EX : c_STALL_NONE;

    // Stall sources are combinational from inputs, so force the bus quiet during reset
    assign stall        = rst ? (w_lu_stall | w_md_stall | w_mem_stall) : c_STALL_NONE;
    assign md_start     = rst && (r_state_q == S_START);
    assign md_result_we = rst && (r_state_q == S_DONE);
    assign md_busy      = rst && (r_state_q != S_IDLE);
    assign md_timeout   = r_md_timeout_q;

endmodule

`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall scheduler for the 5-stage MIPS pipeline; produces the 6-bit stall bus consumed by the PC, IF, ID, EX, MEM and WB pipeline registers.
- Merges three stall sources:
  - the ID-stage load-use hazard, detected internally;
  - multi-cycle mul/div sequencing in EX, via an FSM with a start/done handshake to the mul/div unit;
  - data-SRAM wait from MEM.
- Replaces per-stage ad-hoc stallreq wiring.

Parameters:
- MUL_LAT, 3, fixed multiplier latency in cycles (≥1); multiplier has no done signal.
- DIV_TIMEOUT, 40, cycles to wait for div_done before flagging an error.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_TIMEOUT).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_valid  in  1  EX holds a real instruction
- ex_is_load  in  1  EX instruction is lw/lb/lh/lbu/lhu
- ex_rf_waddr  in  5  EX destination register
- ex_md_req  in  1  EX instruction is mult/multu/div/divu
- ex_md_is_div  in  1  1 = div/divu, 0 = mult/multu
- md_done  in  1  divider result ready (1-cycle pulse)
- mem_stallreq  in  1  data SRAM not ready; hold through MEM
- md_start  out  1  1-cycle start pulse to the mul/div unit
- md_result_we  out  1  1-cycle pulse: EX latches the mul/div result into hi/lo
- md_timeout  out  1  sticky: divider failed to respond within DIV_TIMEOUT
- stall  out  6  stall bus, bit0 = PC … bit5 = WB; 1 = Stop
- md_busy  out  1  FSM not IDLE

Behaviour:
- Reset: async when rst=0. state=IDLE, cnt=0, md_timeout=0. Outputs md_start=0, md_result_we=0, md_busy=0, stall=6'b000000 for the whole time rst is low.
- Stall output:
  - Combinational: stall = lu_stall | md_stall | mem_stall (bitwise OR). All three are thermometer codes, so the OR is the deepest request.
  - lu_stall = 6'b000111 when hazard, else 0.
  - hazard = id_valid & ex_valid & ex_is_load & (ex_rf_waddr≠0) & ((id_use_rs & id_rs==ex_rf_waddr) | (id_use_rt & id_rt==ex_rf_waddr)).
  - mem_stall = 6'b011111 when mem_stallreq, else 0.
  - md_stall = 6'b001111 in states START, DIV_WAIT and MUL_CNT, else 0.
- Load-use: purely combinational, zero latency. Stop on ID with NoStop on EX injects the bubble. No state is kept; the hazard clears naturally next cycle because ex_valid becomes 0.
- FSM states: IDLE, START, DIV_WAIT, MUL_CNT, DONE.
  - IDLE: on ex_md_req & ex_valid → START.
  - START: md_start=1 for exactly this cycle; cnt ← 0. Then ex_md_is_div ? DIV_WAIT : MUL_CNT.
  - MUL_CNT: cnt increments each cycle; when cnt==MUL_LAT-1 → DONE.
  - DIV_WAIT: cnt increments.
    - md_done=1 → DONE.
    - Else cnt==DIV_TIMEOUT-1 → set md_timeout and go to DONE (the result is garbage but the pipeline does not hang).
  - DONE: md_result_we=1 for one cycle; md_stall released. ex_md_req is ignored in this cycle because it is still the same instruction. Then → IDLE.
- md_done is ignored outside DIV_WAIT.
- Mem stall during START, DIV_WAIT or MUL_CNT: the FSM keeps advancing (the mul/div unit runs independently); only the stall OR deepens.
- Mem stall in DONE: md_result_we still pulses exactly once. EX is held by stall[3], and EX must latch the result on that pulse irrespective of stall.
- Back-to-back mul/div: after DONE→IDLE, a new ex_md_req is accepted in IDLE the next cycle. Minimum spacing is START…DONE then IDLE: MUL_LAT+3 cycles for mult.
- md_timeout clears only on reset.
- Reset mid-operation: the FSM returns to IDLE immediately and asynchronously. The mul/div unit shares rst and aborts too.

Decomposition:
- Shared defines header, alongside the existing StallBus/Stop/NoStop macros:
  - `StallBus width;
  - stall codes STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111, STALL_MEM=6'b011111;
  - FSM state encodings.
- One sub-module: hazard_detect, holding the combinational load-use compare. It is reused later for CP0/mfhi hazards.

Test Plan:
- Load-use: ex lw, waddr=5; ID addu with rs=5 → stall=6'b000111 for one cycle, then 0. Repeat with waddr=0 → stall stays 0.
- mult with MUL_LAT=3: ex_md_req=1, is_div=0 → md_start pulses at cycle 1; stall=001111 in cycles 1–4; md_result_we=1 and stall=0 in cycle 5.
- div with md_done after 33 cycles in DIV_WAIT → stall held, md_result_we one cycle after done, md_timeout=0.
- div with no md_done → md_timeout=1 once DIV_TIMEOUT cycles elapse in DIV_WAIT; FSM returns to IDLE; stall drops.
- mem_stallreq=1 during MUL_CNT plus a concurrent load-use → stall=011111. md_result_we pulses exactly once even with mem_stallreq held through DONE.
- rst low mid-DIV_WAIT → md_busy=0, stall=0, md_start=0 asynchronously; no md_result_we after release.
